// File: rtl/lut_func_pkg.sv
// lut_func_pkg: shared scan states, default constants and width helpers for lut_func_engine
package lut_func_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} scan_state_e;
    localparam logic [4:0]  DEF_FLAG_KEY  = 5'b11001;
    localparam logic [15:0] DEF_RESET_TT0 = 16'h0AB7;
    function automatic int sel_w(input int n_func);
        return n_func > 1 ? $clog2(n_func) : 1;
    endfunction
    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction
endpackage

// File: rtl/lut_func_scan.sv
// lut_func_scan: walks one truth-table row a minterm per cycle and reports its ones count
module lut_func_scan import lut_func_pkg::*; #(
    parameter  int N_IN   = 4,
    parameter  int N_FUNC = 4,
    localparam int SW     = sel_w(N_FUNC),
    localparam int CW     = cnt_w(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [SW-1:0]        func_i,
    input  logic [2**N_IN-1:0]   row_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SW-1:0]        func_o,
    output logic [CW-1:0]        count_o
);
    scan_state_e     state_q, state_d;
    logic [N_IN-1:0] idx_q;
    logic [CW-1:0]   acc_q, acc_d;

    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state_q == IDLE ? (!start_i ? IDLE : int'(func_i) < N_FUNC ? RUN : DONE) :
                  state_q == RUN  ? (&idx_q ? DONE : RUN) :
                  IDLE;
    end

    always_comb begin
        busy_o = state_q != IDLE;
        done_o = state_q == DONE;
    end

    assign acc_d = acc_q + CW'(row_i[idx_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            func_o  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            count_o <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                func_o <= func_i;
                idx_q  <= '0;
                acc_q  <= '0;
            end
            if (state_q == RUN) begin
                idx_q <= idx_q + N_IN'(1);
                acc_q <= acc_d;
            end
            if (state_d == DONE && state_q != DONE) count_o <= state_q == RUN ? acc_d : '0;
        end
    end
endmodule

// File: rtl/lut_func_engine.sv
// lut_func_engine: run-time loadable, flag-gated truth-table evaluator with a concurrent minterm scan
module lut_func_engine import lut_func_pkg::*; #(
    parameter  int                 N_IN      = 4,
    parameter  int                 N_FUNC    = 4,
    parameter  int                 FLAG_W    = 5,
    parameter  logic [FLAG_W-1:0]  FLAG_KEY  = DEF_FLAG_KEY,
    parameter  logic [2**N_IN-1:0] RESET_TT0 = DEF_RESET_TT0,
    localparam int                 SW        = sel_w(N_FUNC),
    localparam int                 CW        = cnt_w(N_IN),
    localparam int                 D         = 2**N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [SW-1:0]     cfg_sel,
    input  logic [N_IN-1:0]   cfg_addr,
    input  logic              cfg_data,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLAG_W-1:0] in_flag,
    input  logic [SW-1:0]     in_func,
    input  logic [N_IN-1:0]   in_vars,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic              out_en,
    input  logic              scan_start,
    input  logic [SW-1:0]     scan_func,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [CW-1:0]     scan_count
);
    logic [D-1:0]  tt_q [N_FUNC];
    logic [D-1:0]  eval_row, scan_row;
    logic [SW-1:0] scan_f;
    logic          cfg_ok, en_d, cfg_err_q, out_valid_q, out_y_q, out_en_q;

    // Row muxes never index past N_FUNC; out-of-range selects read as all-zero
    always_comb begin
        eval_row = '0;
        scan_row = '0;
        for (int i = 0; i < N_FUNC; i++) begin
            eval_row = in_func == SW'(i) ? tt_q[i] : eval_row;
            scan_row = scan_f  == SW'(i) ? tt_q[i] : scan_row;
        end
    end

    assign cfg_ok = int'(cfg_sel) < N_FUNC && !(scan_busy && cfg_sel == scan_f);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_FUNC; i++) tt_q[i] <= i == 0 ? RESET_TT0 : '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_FUNC; i++)
                if (cfg_we && cfg_ok && cfg_sel == SW'(i)) tt_q[i][cfg_addr] <= cfg_data;
            cfg_err_q <= cfg_we && !cfg_ok;
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign en_d     = in_flag == FLAG_KEY && int'(in_func) < N_FUNC;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_en_q    <= 1'b0;
        end else if (in_ready) begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_en_q <= en_d;
                out_y_q  <= en_d && eval_row[in_vars];
            end
        end
    end

    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_en    = out_en_q;

    lut_func_scan #(.N_IN(N_IN), .N_FUNC(N_FUNC)) u_scan (
        .clk     (clk),
        .rst     (rst),
        .start_i (scan_start),
        .func_i  (scan_func),
        .row_i   (scan_row),
        .busy_o  (scan_busy),
        .done_o  (scan_done),
        .func_o  (scan_f),
        .count_o (scan_count)
    );
endmodule

// File: tb/tb_lut_func_engine.sv
// tb_lut_func_engine: directed and randomized checks of lut_func_engine against a behavioural model
module tb_lut_func_engine;
    localparam int         NF  = 3;
    localparam logic [4:0] KEY = 5'b11001;

    logic       clk = 1'b0, rst = 1'b1;
    logic       cfg_we = 1'b0, cfg_data = 1'b0, cfg_err;
    logic [1:0] cfg_sel = '0, in_func = '0, scan_func = '0;
    logic [3:0] cfg_addr = '0, in_vars = '0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_y, out_en;
    logic [4:0] in_flag = '0, scan_count;
    logic       scan_start = 1'b0, scan_busy, scan_done;

    always #5 clk = ~clk;

    lut_func_engine #(.N_IN(4), .N_FUNC(NF)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_flag(in_flag), .in_func(in_func), .in_vars(in_vars),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_en(out_en),
        .scan_start(scan_start), .scan_func(scan_func), .scan_busy(scan_busy), .scan_done(scan_done),
        .scan_count(scan_count)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int ones_after_write(input logic [15:0] r, input logic w, input logic [3:0] a, input logic d);
        if (w) r[a] = d;
        return $countones(r);
    endfunction

    // Behavioural model: table contents, one result slot, and a scan countdown of remaining busy cycles
    logic [15:0] m_tt [4];
    logic        m_ov = 1'b0, m_y = 1'b0, m_en = 1'b0, m_err = 1'b0, m_init = 1'b0, m_wr_ok, m_en_d;
    logic [1:0]  m_sf = '0;
    logic [4:0]  m_pend = '0, m_count = '0;
    int          m_left = 0;

    assign m_wr_ok = cfg_we && int'(cfg_sel) < NF && !(m_left > 0 && cfg_sel == m_sf);
    assign m_en_d  = in_flag == KEY && int'(in_func) < NF;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_tt[i] <= i == 0 ? 16'h0AB7 : 16'h0000;
            m_ov <= 1'b0; m_y <= 1'b0; m_en <= 1'b0; m_err <= 1'b0;
            m_left <= 0; m_count <= '0; m_init <= 1'b1;
        end else begin
            if (in_valid && (!m_ov || out_ready)) begin
                m_ov <= 1'b1;
                m_en <= m_en_d;
                m_y  <= m_en_d && m_tt[in_func][in_vars];
            end else if (out_ready) m_ov <= 1'b0;
            m_err <= cfg_we && !m_wr_ok;
            if (m_wr_ok) m_tt[cfg_sel][cfg_addr] <= cfg_data;
            if (m_left == 0 && scan_start) begin
                m_sf   <= scan_func;
                m_left <= int'(scan_func) < NF ? 17 : 1;
                m_pend <= 5'(ones_after_write(m_tt[scan_func], m_wr_ok && cfg_sel == scan_func, cfg_addr, cfg_data));
                if (int'(scan_func) >= NF) m_count <= '0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 2) m_count <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("out_valid", int'(out_valid), int'(m_ov));
            if (m_ov) begin
                chk("out_y", int'(out_y), int'(m_y));
                chk("out_en", int'(out_en), int'(m_en));
            end
            chk("in_ready", int'(in_ready), int'(!m_ov || out_ready));
            chk("cfg_err", int'(cfg_err), int'(m_err));
            chk("scan_busy", int'(scan_busy), int'(m_left > 0));
            chk("scan_done", int'(scan_done), int'(m_left == 1));
            chk("scan_count", int'(scan_count), int'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [4:0] f, input logic [1:0] fn, input logic [3:0] v);
        in_valid = 1'b1; in_flag = f; in_func = fn; in_vars = v;
    endtask

    int nb, nd, dc;

    initial begin
        tick(); tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_en", int'(out_en), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_scan_busy", int'(scan_busy), 0);
        chk("rst_scan_count", int'(scan_count), 0);
        chk("model_tt0", int'(m_tt[0]), 32'h0AB7);
        rst = 1'b0;
        ev(KEY, 0, 4'b0000); tick();
        chk("ev0_valid", int'(out_valid), 1);
        chk("ev0_y", int'(out_y), 1);
        chk("ev0_en", int'(out_en), 1);
        ev(KEY, 0, 4'b0011); tick();
        chk("ev3_y", int'(out_y), 0);
        chk("ev3_en", int'(out_en), 1);
        ev(KEY, 0, 4'b0111); tick();
        chk("ev7_y", int'(out_y), 1);
        ev(5'b11000, 0, 4'b0000); tick();
        chk("badflag_y", int'(out_y), 0);
        chk("badflag_en", int'(out_en), 0);
        ev(KEY, 3, 4'b0000); tick();
        chk("badfunc_en", int'(out_en), 0);
        chk("badfunc_y", int'(out_y), 0);
        in_valid = 1'b0; tick();
        chk("drain", int'(out_valid), 0);
        out_ready = 1'b0;
        ev(KEY, 0, 4'b0000); tick();
        chk("bp_first", int'({out_valid, out_y}), 3);
        ev(KEY, 0, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", int'(in_ready), 0);
            tick();
            chk("bp_hold", int'({out_valid, out_y}), 3);
        end
        out_ready = 1'b1; #1;
        chk("bp_ready_up", int'(in_ready), 1);
        tick();
        chk("bp_second", int'({out_valid, out_y}), 2);
        in_valid = 1'b0; tick();
        chk("bp_nodup", int'(out_valid), 0);
        cfg_we = 1'b1; cfg_sel = 1; cfg_addr = 5; cfg_data = 1'b1;
        ev(KEY, 1, 4'd5); tick();
        cfg_we = 1'b0;
        chk("cfg_same_cycle_old", int'(out_y), 0);
        chk("cfg_same_cycle_en", int'(out_en), 1);
        tick();
        chk("cfg_next_new", int'(out_y), 1);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_sel = 3; tick();
        cfg_we = 1'b0;
        chk("cfg_range_err", int'(cfg_err), 1);
        tick();
        chk("cfg_err_pulse", int'(cfg_err), 0);
        scan_start = 1'b1; scan_func = 0; tick();
        scan_start = 1'b0;
        nb = 0; nd = 0; dc = 0;
        for (int c = 1; c <= 25; c++) begin
            if (scan_busy) nb++;
            if (scan_done) begin nd++; dc = c; end
            if (c == 4) chk("scan_write_err", int'(cfg_err), 1);
            cfg_we = c == 3; cfg_sel = 0; cfg_addr = 0; cfg_data = 1'b0;
            scan_start = c == 3; scan_func = 1;
            tick();
        end
        chk("scan_busy_len", nb, 17);
        chk("scan_done_at", dc, 17);
        chk("scan_done_once", nd, 1);
        chk("scan_count8", int'(scan_count), 8);
        scan_start = 1'b1; scan_func = 3; tick();
        scan_start = 1'b0;
        chk("oor_busy", int'(scan_busy), 1);
        chk("oor_done", int'(scan_done), 1);
        chk("oor_count", int'(scan_count), 0);
        tick();
        chk("oor_idle", int'(scan_busy), 0);
        out_ready = 1'b0;
        ev(KEY, 0, 4'b0000); scan_start = 1'b1; scan_func = 0; tick();
        scan_start = 1'b0; in_valid = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rstmid_busy", int'(scan_busy), 0);
        chk("rstmid_count", int'(scan_count), 0);
        chk("rstmid_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        ev(KEY, 1, 4'd5); tick();
        in_valid = 1'b0;
        chk("rstmid_tt1", int'(out_y), 0);
        scan_start = 1'b1; scan_func = 0; tick();
        scan_start = 1'b0;
        dc = 0;
        for (int c = 1; c <= 30; c++) begin
            if (scan_done && dc == 0) dc = c;
            tick();
        end
        chk("rescan_done_at", dc, 17);
        chk("rescan_count", int'(scan_count), 8);
        for (int i = 0; i < 3000; i++) begin
            rst        = $urandom_range(0, 599) == 0;
            in_valid   = $urandom_range(0, 3) != 0;
            in_flag    = $urandom_range(0, 3) != 0 ? KEY : 5'($urandom);
            in_func    = 2'($urandom);
            in_vars    = 4'($urandom);
            out_ready  = $urandom_range(0, 3) != 0;
            cfg_we     = $urandom_range(0, 2) == 0;
            cfg_sel    = 2'($urandom);
            cfg_addr   = 4'($urandom);
            cfg_data   = 1'($urandom);
            scan_start = $urandom_range(0, 15) == 0;
            scan_func  = 2'($urandom);
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lut_func_engine.md
# lut_func_engine

Programmable, flag-gated truth-table evaluator holding N_FUNC run-time-loadable Boolean functions of N_IN variables. It evaluates one request per cycle through a valid/ready pipeline stage. An independent scan engine counts the minterms of any stored function. It sits beside the combinational decoders in the trig/logic-function group and replaces fixed-table, flag-keyed function blocks with one configurable instance.

## Interface
- N_IN, 4, number of input variables; table depth is 2**N_IN
- N_FUNC, 4, number of stored functions
- FLAG_W, 5, width of the enable flag
- FLAG_KEY, 5'b11001, flag value that enables evaluation
- RESET_TT0, 16'h0AB7, reset contents of function 0; width is 2**N_IN; bit i is the output for minterm i
- clk  in  1  sole clock; everything is rising-edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write one table bit this cycle
- cfg_sel  in  clog2(N_FUNC)  function to write
- cfg_addr  in  N_IN  minterm index
- cfg_data  in  1  bit value
- cfg_err  out  1  one-cycle pulse: write rejected
- in_valid / in_ready  in / out  1  request handshake
- in_flag  in  FLAG_W  enable flag
- in_func  in  clog2(N_FUNC)  function select
- in_vars  in  N_IN  variable vector; MSB is first variable
- out_valid / out_ready  out / in  1  result handshake
- out_y  out  1  function value; 0 when out_en=0
- out_en  out  1  1 = flag matched and func in range (replaces high-Z)
- scan_start  in  1  start a minterm count
- scan_func  in  clog2(N_FUNC)  function to scan
- scan_busy, scan_done  out  1  scan in progress; one-cycle completion pulse
- scan_count  out  N_IN+1  number of 1 minterms

## Operation
- Reset: function 0 = RESET_TT0, other functions all-zero. out_valid, out_y, out_en, cfg_err, scan_busy, scan_done = 0; scan_count = 0; scan FSM = IDLE.
- Config: a write with cfg_we=1 lands at the clock edge. It is rejected (table unchanged, cfg_err=1 next cycle) if cfg_sel >= N_FUNC, or if scan_busy=1 and cfg_sel equals the latched scan function.
- Eval: in_ready = !out_valid || out_ready. A request is accepted when in_valid && in_ready.
  - Result registered next cycle: out_en = (in_flag==FLAG_KEY) && (in_func<N_FUNC); out_y = out_en ? table[in_func][in_vars] : 0.
  - out_* hold stable while out_valid && !out_ready.
- Scan FSM:
  - IDLE: scan_start latches scan_func, clears idx and count, goes to RUN.
  - RUN: each cycle count += table[f][idx], idx++. After idx = 2**N_IN-1 is counted, go to DONE.
  - DONE: scan_done=1 for one cycle, then IDLE.
  - scan_busy=1 in RUN and DONE. scan_start while busy is ignored.
  - scan_count updates only on entry to DONE and holds until the next DONE.
  - scan_func >= N_FUNC: no RUN; go straight to DONE with count 0.
- Config and eval may occur in the same cycle; scan may run concurrently with both. Each uses its own read port.

## Timing
- Eval latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle when out_ready=1.
- Same-cycle write and eval to the same entry: eval sees the old value. A request accepted the following cycle sees the new value.
- Scan: start accepted at cycle 0; RUN spans cycles 1..2**N_IN; scan_done at cycle 2**N_IN+1.
- Reset mid-operation: the pending result is dropped (out_valid=0), the scan is aborted (scan_busy=0, scan_count=0), and tables return to their reset contents.
- Counter width: N_IN+1, so a full count of 2**N_IN does not wrap.

## Structure
- Package lut_func_pkg:
  - scan state enum (IDLE, RUN, DONE)
  - default FLAG_KEY and RESET_TT0 constants
  - width helper functions for clog2(N_FUNC) and N_IN+1
- Sub-module lut_func_scan: scan FSM, index counter and accumulator. It reads the table through a 2**N_IN-bit row input selected by the parent.
- The table is a flop array of N_FUNC x 2**N_IN bits in the parent.

## Test plan
- Reset state: after reset, flag 5'b11001, func 0 -> vars 4'b0000 gives y=1, en=1; vars 4'b0011 gives y=0, en=1; vars 4'b0111 gives y=1. All results arrive 1 cycle after accept.
- Flag/range gating: flag 5'b11000, vars 0 -> y=0, en=0. With N_FUNC=3, func 3 -> en=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, first result held stable, second accepted the cycle out_ready rises, no loss or duplication.
- Config:
  - write func 1, addr 5, data 1, with an eval of the same entry in the same cycle -> that eval returns 0.
  - the next eval returns 1.
  - cfg_sel = N_FUNC -> cfg_err pulse, no table change.
- Scan: scan func 0 after reset -> scan_busy for 17 cycles, scan_done at cycle 17, scan_count=8. A write to func 0 during the scan -> cfg_err. scan_start mid-scan is ignored.
- Reset mid-scan at cycle 6 -> scan_busy=0, scan_count=0; a new scan afterwards completes normally with count 8.
